// File: rtl/nxxxx_packer.sv
// nxxxx_packer -- record-packing stage of the gene compressor.
//
// The block pulls 160-bit records from the upstream buffer, one per read
// pulse. Each record becomes a 32-bit entry {tag, field}. Four entries are
// packed into one 128-bit word, which is handed to the downstream writer with
// a one-cycle write strobe. A record with tag 0 is a flush: it closes the
// current partial word, if there is one.
//
// Configuration macro: NXXXX_DELTA_EN
//   defined   : field = (position - prev)[27:0]  (delta coding)
//   undefined : field = position[27:0]            (absolute coding)
//
// Ports
//   clk  in   1    rising-edge clock
//   rst  in   1    synchronous active-high reset
//   In   in   160  record: [35:32] tag, [31:0] position, [159:36] ignored
//   Out  out  128  packed word, slot0 in [31:0] .. slot3 in [127:96]
//   R    out  1    read request pulse; the record is sampled as REQ ends
//   W    out  1    write strobe; Out is valid while it is high
module nxxxx_packer (
  input  logic         clk,
  input  logic         rst,
  input  logic [159:0] In,
  output logic [127:0] Out,
  output logic         R,
  output logic         W
);

  typedef enum logic [1:0] {
    ST_GAP  = 2'd0,
    ST_REQ  = 2'd1,
    ST_EMIT = 2'd2
  } state_t;

  state_t       state_r;
  logic [127:0] acc_r;
  logic [127:0] out_r;
  logic [1:0]   count_r;
  logic         r_r;
  logic         w_r;
`ifdef NXXXX_DELTA_EN
  logic [31:0]  prev_r;
  logic [31:0]  diff_s;
`endif

  logic [3:0]   tag_s;
  logic [31:0]  pos_s;
  logic [27:0]  field_s;
  logic [31:0]  entry_s;
  logic [127:0] merged_s;
  logic         is_flush_s;
  logic         unused_s;

  // Upper record bits carry nothing this stage needs.
`ifdef NXXXX_DELTA_EN
  assign unused_s = ^In[159:36];
`else
  assign unused_s = ^{In[159:36], In[31:28]};
`endif

  // Build the entry for the record on In and merge it into the accumulator.
  always_comb begin
    tag_s      = In[35:32];
    pos_s      = In[31:0];
`ifdef NXXXX_DELTA_EN
    // Modulo arithmetic: decreasing positions simply wrap.
    diff_s     = pos_s - prev_r;
    field_s    = diff_s[27:0];
`else
    field_s    = pos_s[27:0];
`endif
    entry_s    = {tag_s, field_s};
    is_flush_s = (tag_s == 4'd0);
    merged_s   = acc_r;
    case (count_r)
      2'd0:    merged_s[31:0]   = entry_s;
      2'd1:    merged_s[63:32]  = entry_s;
      2'd2:    merged_s[95:64]  = entry_s;
      2'd3:    merged_s[127:96] = entry_s;
      default: merged_s         = acc_r;
    endcase
  end

  // Request/gap/emit sequencer with registered R, W and Out.
  // EMIT takes the place of GAP, so a record is requested every 2 cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_GAP;
      acc_r   <= 128'd0;
      out_r   <= 128'd0;
      count_r <= 2'd0;
      r_r     <= 1'b0;
      w_r     <= 1'b0;
`ifdef NXXXX_DELTA_EN
      prev_r  <= 32'd0;
`endif
    end else begin
      case (state_r)
        ST_REQ: begin
          r_r <= 1'b0;
          if (is_flush_s) begin
            // Slots not yet written are still zero in the accumulator.
            acc_r   <= 128'd0;
            count_r <= 2'd0;
`ifdef NXXXX_DELTA_EN
            prev_r  <= 32'd0;
`endif
            if (count_r != 2'd0) begin
              out_r   <= acc_r;
              w_r     <= 1'b1;
              state_r <= ST_EMIT;
            end else begin
              w_r     <= 1'b0;
              state_r <= ST_GAP;
            end
          end else if (count_r == 2'd3) begin
            out_r   <= merged_s;
            acc_r   <= 128'd0;
            count_r <= 2'd0;
            w_r     <= 1'b1;
            state_r <= ST_EMIT;
`ifdef NXXXX_DELTA_EN
            prev_r  <= pos_s;
`endif
          end else begin
            acc_r   <= merged_s;
            count_r <= count_r + 2'd1;
            w_r     <= 1'b0;
            state_r <= ST_GAP;
`ifdef NXXXX_DELTA_EN
            prev_r  <= pos_s;
`endif
          end
        end
        ST_GAP: begin
          r_r     <= 1'b1;
          w_r     <= 1'b0;
          state_r <= ST_REQ;
        end
        ST_EMIT: begin
          r_r     <= 1'b1;
          w_r     <= 1'b0;
          state_r <= ST_REQ;
        end
        default: begin
          r_r     <= 1'b0;
          w_r     <= 1'b0;
          state_r <= ST_GAP;
        end
      endcase
    end
  end

  assign Out = out_r;
  assign R   = r_r;
  assign W   = w_r;

endmodule

// File: tb/tb_nxxxx_packer.sv
// Scoreboard bench for nxxxx_packer. Expected words are pushed when records
// are queued; a monitor pops and compares on every W pulse.
module tb_nxxxx_packer;

  logic         clk = 1'b0;
  logic         rst;
  logic [159:0] In;
  logic [127:0] Out;
  logic         R;
  logic         W;

  nxxxx_packer dut (
    .clk (clk),
    .rst (rst),
    .In  (In),
    .Out (Out),
    .R   (R),
    .W   (W)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int w_count  = 0;

  logic [159:0] recq[$];
  logic [127:0] sbq[$];

  int last_r, last_w, r0;
  bit have_r    = 1'b0;
  bit have_w    = 1'b0;
  bit chk7      = 1'b0;
  bit space_chk = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [159:0] rec(input logic [3:0] tag, input logic [31:0] pos);
    return {124'd0, tag, pos};
  endfunction

  function automatic logic [159:0] rec_up(input logic [3:0] tag, input logic [31:0] pos);
    logic [159:0] v;
    logic [127:0] u;
    u = {$urandom(), $urandom(), $urandom(), $urandom()};
    v = rec(tag, pos);
    v[159:36] = u[123:0];
    return v;
  endfunction

  // Upstream model: answer each read request with the next queued record,
  // or a flush record when nothing is queued.
  initial begin
    In = 160'd0;
    forever begin
      @(negedge clk);
      if (R === 1'b1) begin
        if (recq.size() > 0) In = recq.pop_front();
        else In = 160'd0;
      end
    end
  end

  // Monitor: R cadence, W/R exclusion, word contents and W timing.
  initial begin
    logic [127:0] exp;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        have_r = 1'b0;
        have_w = 1'b0;
      end else begin
        if (R === 1'b1) begin
          if (have_r) chk("r_period", 128'(cyc - last_r), 128'd2);
          last_r = cyc;
          have_r = 1'b1;
        end
        if (W === 1'b1) begin
          w_count++;
          chk("w_r_exclusive", {127'd0, R}, 128'd0);
          if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_w actual=%h expected=no_write", Out);
          end else begin
            exp = sbq.pop_front();
            chk("out_word", Out, exp);
          end
          if (chk7) begin
            chk("first_w_cycle", 128'(cyc - r0), 128'd7);
            chk7 = 1'b0;
          end
          if (space_chk && have_w) chk("w_period", 128'(cyc - last_w), 128'd8);
          last_w = cyc;
          have_w = 1'b1;
        end
      end
    end
  end

  task automatic wait_done();
    int n;
    n = 0;
    while ((recq.size() != 0 || sbq.size() != 0) && n < 400) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (n >= 400) begin
      failures++;
      $display("FAIL drain_timeout actual=%0d expected=%0d", sbq.size(), 0);
    end
    // Idle flush records follow, so every test starts with prev cleared.
    repeat (8) @(posedge clk);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out", Out, 128'd0);
    chk("reset_r", {127'd0, R}, 128'd0);
    chk("reset_w", {127'd0, W}, 128'd0);

    // Test 1: a:0 a:5 b:4 c:3, W at cycle 7 after the first R.
`ifdef NXXXX_DELTA_EN
    sbq.push_back(128'hcFFFFFFF_bFFFFFFF_a0000005_a0000000);
`else
    sbq.push_back(128'hc0000003_b0000004_a0000005_a0000000);
`endif
    recq.push_back(rec(4'ha, 32'd0));
    recq.push_back(rec(4'ha, 32'd5));
    recq.push_back(rec(4'hb, 32'd4));
    recq.push_back(rec(4'hc, 32'd3));
    chk7 = 1'b1;
    rst  = 1'b0;
    @(negedge clk);
    chk("first_r_after_reset", {127'd0, R}, 128'd1);
    r0 = cyc;
    wait_done();

    // Test 2: same record for every request, three words 8 cycles apart.
    space_chk = 1'b1;
    have_w    = 1'b0;
`ifdef NXXXX_DELTA_EN
    sbq.push_back(128'hc0000000_c0000000_c0000000_c0000007);
    sbq.push_back(128'hc0000000_c0000000_c0000000_c0000000);
    sbq.push_back(128'hc0000000_c0000000_c0000000_c0000000);
`else
    for (int i = 0; i < 3; i++) sbq.push_back(128'hc0000007_c0000007_c0000007_c0000007);
`endif
    for (int i = 0; i < 12; i++) recq.push_back(160'hc00000007);
    wait_done();
    space_chk = 1'b0;

    // Test 3: partial word closed by a flush, then a flush at count 0.
`ifdef NXXXX_DELTA_EN
    sbq.push_back(128'h00000000_00000000_e0000001_d0000002);
`else
    sbq.push_back(128'h00000000_00000000_e0000003_d0000002);
`endif
    recq.push_back(rec(4'hd, 32'd2));
    recq.push_back(rec(4'he, 32'd3));
    recq.push_back(rec(4'h0, 32'd0));
    wait_done();
    recq.push_back(rec(4'h0, 32'd77));
    wait_done();

    // Test 4: reset after two data records discards the partial word.
    recq.push_back(rec(4'hd, 32'd9));
    recq.push_back(rec(4'he, 32'd11));
    n = 0;
    while (recq.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_out", Out, 128'd0);
    chk("midreset_r", {127'd0, R}, 128'd0);
    chk("midreset_w", {127'd0, W}, 128'd0);
`ifdef NXXXX_DELTA_EN
    sbq.push_back(128'he0000001_f0000001_e0000001_d0000002);
`else
    sbq.push_back(128'he0000005_f0000004_e0000003_d0000002);
`endif
    recq.push_back(rec(4'hd, 32'd2));
    recq.push_back(rec(4'he, 32'd3));
    recq.push_back(rec(4'hf, 32'd4));
    recq.push_back(rec(4'he, 32'd5));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("r_after_midreset", {127'd0, R}, 128'd1);
    wait_done();

    // Test 5: random upper record bits must not reach Out.
    for (int k = 0; k < 2; k++) begin
`ifdef NXXXX_DELTA_EN
      sbq.push_back(128'hd0000001_c0000001_b0000001_a0000001);
`else
      sbq.push_back(128'hd0000004_c0000003_b0000002_a0000001);
`endif
      recq.push_back(rec_up(4'ha, 32'd1));
      recq.push_back(rec_up(4'hb, 32'd2));
      recq.push_back(rec_up(4'hc, 32'd3));
      recq.push_back(rec_up(4'hd, 32'd4));
      recq.push_back(rec_up(4'h0, 32'd0));
    end
    wait_done();

    chk("total_words", 128'(w_count), 128'd8);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d expected=finished", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/nxxxx_packer.md
# nxxxx_packer

Record-packing stage of the gene compressor. It pulls 160-bit records from the upstream buffer one at a time with a read strobe. Each record becomes a 32-bit entry holding a tag and a position field, and four entries are packed into one 128-bit word. Each completed word is presented to the downstream writer with a one-cycle write strobe.

## Interface
- No parameters.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous, active-high reset.
- `In`  input  160  record. `In[35:32]` is the tag, `In[31:0]` is the position, `In[159:36]` is ignored.
- `Out`  output  128  packed word: slot0 in `[31:0]`, slot1 in `[63:32]`, slot2 in `[95:64]`, slot3 in `[127:96]`.
- `R`  output  1  read request, a one-cycle pulse. Upstream places the next record on `In` in response to its rising edge.
- `W`  output  1  write strobe, one cycle. `Out` is valid while it is high.

## Operation
- Entry format: `{tag[3:0], field[27:0]}`. `field` depends on the configuration macro (see Configuration).
- The block keeps a 128-bit accumulator, a 2-bit slot count (0..3) and a 32-bit previous position `prev`.
- Data record (tag ≠ 0):
  - The entry is written into slot[count] and `prev` takes the new position.
  - count increments.
  - When count reaches 4, the accumulator is copied to `Out`, W pulses, and the accumulator and count are cleared.
- Flush record (tag = 0):
  - The record is not stored.
  - If count > 0, the accumulator is copied to `Out` with unused slots zero and W pulses.
  - If count = 0, no W pulse.
  - In both cases the accumulator, count and `prev` are cleared.
- States:
  - REQ: R=1. `In` is sampled on the edge that leaves REQ.
  - GAP: R=0.
  - EMIT: W=1.
- Transitions:
  - REQ → EMIT if the sampled record completes a word or is a flush with count > 0; otherwise REQ → GAP.
  - GAP → REQ.
  - EMIT → REQ.
- Position arithmetic is modulo 2^28. Wrap-around and decreasing positions are legal and produce no error.

## Timing
- Reset values: `Out`=0, R=0, W=0, accumulator=0, count=0, `prev`=0, state=GAP.
- The first R rises one cycle after `rst` falls.
- Steady-state throughput is one record per 2 cycles. The EMIT cycle replaces the GAP cycle, so emitting never adds a cycle.
- With the first REQ as cycle 0, the word built from the first four records has W high at cycle 7, and the next R is at cycle 8.
- `Out` is registered and updated on the edge entering EMIT. It holds its value until the next EMIT or reset.
- W and R are never high in the same cycle.
- Reset asserted at any point, including during EMIT, applies the reset values on that edge and discards any partial word.

## Configuration
- Macro `NXXXX_DELTA_EN`.
- Defined: `field = (position − prev)[27:0]`, i.e. delta coding against the previous data record. `prev` is 0 after reset or a flush.
- Undefined: `field = position[27:0]`, absolute coding, and `prev` is unused.
- All other behaviour is identical in both builds.

## Test plan
- Delta build: records a:0, a:5, b:4, c:3 → one W at cycle 7 with `Out` = `cFFFFFFF_bFFFFFFF_a0000005_a0000000`.
- Absolute build, same stimulus → `Out` = `c0000003_b0000004_a0000005_a0000000`.
- Delta build: `In` held at `160'hc00000007` for every request → first word `Out` = `c0000000_c0000000_c0000000_c0000007`. R pulses every 2 cycles and every W is exactly 8 cycles apart.
- Flush: records d:2, e:3, then tag 0 → W with `Out` = `00000000_00000000_e0000001_d0000002` (delta build). A flush at count 0 gives no W.
- Reset mid-word: assert `rst` after two data records → outputs return to 0 and no stale slots appear. The next four records d:2, e:3, f:4, e:5 give `Out` = `e0000001_f0000001_e0000001_d0000002` (delta build).
- Upper bits: vary `In[159:36]` with fixed `In[35:0]` → `Out` is unchanged.
